// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one FP32 add/sub datapath among NUM_REQ requesters,
// with operand registers in front of the adder and a result register behind it.
module floating_point_adder_subtracter (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);
    logic        sb, swap, sl, eff_sub, sticky, rnd;
    logic [7:0]  ea, eb, el, es, d, sh;
    logic [23:0] ml, ms;
    logic [4:0]  ash, lz;
    logic [26:0] ext, mse, nrm;
    logic [27:0] sum;
    logic [8:0]  e, ef;
    logic [24:0] mr;

    assign sb      = b[31] ^ sub;
    assign ea      = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    assign eb      = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    assign swap    = b[30:0] > a[30:0];
    assign el      = swap ? eb : ea;
    assign es      = swap ? ea : eb;
    assign ml      = swap ? {|b[30:23], b[22:0]} : {|a[30:23], a[22:0]};
    assign ms      = swap ? {|a[30:23], a[22:0]} : {|b[30:23], b[22:0]};
    assign sl      = swap ? sb : a[31];
    assign eff_sub = a[31] ^ sb;
    // Align the smaller operand keeping guard, round and a sticky bit.
    assign d       = el - es;
    assign ash     = (d > 8'd27) ? 5'd27 : d[4:0];
    assign ext     = {ms, 3'b000};
    assign sticky  = |(ext & ~({27{1'b1}} << ash));
    assign mse     = (ext >> ash) | {26'd0, sticky};
    assign sum     = eff_sub ? {1'b0, ml, 3'b000} - {1'b0, mse} : {1'b0, ml, 3'b000} + {1'b0, mse};

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
    end

    // Left shift is capped so the exponent never drops below 1 (denormal result).
    assign sh  = ({3'b000, lz} > el - 8'd1) ? el - 8'd1 : {3'b000, lz};
    assign nrm = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << sh;
    assign e   = sum[27] ? {1'b0, el} + 9'd1 : {1'b0, el} - {1'b0, sh};
    assign rnd = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    assign mr  = {1'b0, nrm[26:3]} + {24'd0, rnd};
    assign ef  = mr[24] ? e + 9'd1 : (mr[23] ? e : 9'd0);
    assign y   = (sum == 28'd0) ? {a[31] & sb, 31'd0}
               : (ef >= 9'd255) ? {sl, 8'hFF, 23'd0}
               : {sl, ef[7:0], mr[24] ? mr[23:1] : mr[22:0]};
endmodule

module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_sub,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, gnt, win;
    logic            found, op_sub;
    logic [31:0]     op_a, op_b, sum;

    floating_point_adder_subtracter u_fp (.a(op_a), .b(op_b), .sub(op_sub), .y(sum));

    // Search starts just after the last winner so it gets lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++)
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (found ? EXEC : IDLE)
                  : (state == EXEC) ? RESP
                  : (rsp_ready[gnt] ? IDLE : RESP);
    end

    assign req_ready = (state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << gnt : '0;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= ID_W'(NUM_REQ - 1);
            gnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_sub   <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                ptr    <= win;
                gnt    <= win;
                op_a   <= req_a[32*win +: 32];
                op_b   <= req_b[32*win +: 32];
                op_sub <= req_sub[win];
            end
            if (state == EXEC) begin
                rsp_data <= sum;
                rsp_id   <= gnt;
            end
        end
    end
endmodule
